// File: rtl/sram_arbiter_pkg.sv
// Shared owner encoding and SRAM-like bus field widths for the memory-port arbiter.
package sram_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SIZE_W = 2;
    localparam int STRB_W = 4;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

endpackage

// File: rtl/sram_arbiter_owner_fifo.sv
// Synchronous 1-bit-wide FIFO remembering which requester owns each outstanding transaction.
module owner_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so push at full is legal alongside it.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access,
// returning each response to the requester that issued it.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [SIZE_W-1:0] inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [STRB_W-1:0] inst_wstrb,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [SIZE_W-1:0] data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [STRB_W-1:0] data_wstrb,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              req,
    output logic              wr,
    output logic [SIZE_W-1:0] size,
    output logic [ADDR_W-1:0] addr,
    output logic [STRB_W-1:0] wstrb,
    output logic [DATA_W-1:0] wdata,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    owner_t              grant;
    owner_t              lock_owner;
    owner_t              head_owner;
    logic                locked;
    logic                grant_req;
    logic                handshake;
    logic                resp_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_head;
    logic [STARVE_W-1:0] starve;

    // Data normally wins; inst wins when alone or once data has starved it long enough.
    always_comb begin
        grant = OWNER_INST;
        if (locked) begin
            grant = lock_owner;
        end else if (inst_req && (!data_req || starve == STARVE_MAX)) begin
            grant = OWNER_INST;
        end else if (data_req) begin
            grant = OWNER_DATA;
        end
    end

    assign grant_req = (grant == OWNER_DATA) ? data_req : inst_req;
    assign req       = grant_req && !fifo_full;
    assign wr        = (grant == OWNER_DATA) ? data_wr    : inst_wr;
    assign size      = (grant == OWNER_DATA) ? data_size  : inst_size;
    assign addr      = (grant == OWNER_DATA) ? data_addr  : inst_addr;
    assign wstrb     = (grant == OWNER_DATA) ? data_wstrb : inst_wstrb;
    assign wdata     = (grant == OWNER_DATA) ? data_wdata : inst_wdata;

    assign handshake    = req && addr_ok;
    assign inst_addr_ok = handshake && (grant == OWNER_INST);
    assign data_addr_ok = handshake && (grant == OWNER_DATA);

    // Responses come back in issue order, so the FIFO head names their owner.
    assign resp_pop     = data_ok && !fifo_empty;
    assign head_owner   = owner_t'(fifo_head);
    assign inst_data_ok = resp_pop && (head_owner == OWNER_INST);
    assign data_data_ok = resp_pop && (head_owner == OWNER_DATA);
    assign inst_rdata   = inst_data_ok ? rdata : '0;
    assign data_rdata   = data_data_ok ? rdata : '0;

    owner_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk   (clk),
        .resetn(resetn),
        .push  (handshake),
        .pop   (resp_pop),
        .din   (logic'(grant)),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Bus fields must stay stable until accepted, so a pending request pins the owner.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            locked     <= 1'b0;
            lock_owner <= OWNER_INST;
            starve     <= '0;
            err        <= 1'b0;
        end else begin
            if (req && !addr_ok) begin
                locked     <= 1'b1;
                lock_owner <= grant;
            end else if (addr_ok) begin
                locked <= 1'b0;
            end
            if (handshake && (grant == OWNER_DATA) && inst_req) begin
                if (starve != STARVE_MAX) begin
                    starve <= starve + STARVE_W'(1);
                end
            end else if (!inst_req || (handshake && (grant == OWNER_INST))) begin
                starve <= '0;
            end
            if (data_ok && fifo_empty) begin
                err <= 1'b1;
            end
        end
    end

endmodule
